// File: rtl/irq_pkg.sv
// Shared state encoding, mcause codes and default trap vector for the
// machine-mode interrupt trap sequencer.
package irq_pkg;

   typedef enum logic [2:0] {
      RUN   = 3'd0,
      DRAIN = 3'd1,
      ENTER = 3'd2,
      ISR   = 3'd3,
      SLEEP = 3'd4
   } irq_state_e;

   localparam logic [31:0] CAUSE_MEI      = 32'h8000_000B;
   localparam logic [31:0] CAUSE_MTI      = 32'h8000_0007;
   localparam logic [31:0] ISR_PC_DEFAULT = 32'h0001_0000;

   // Address of the instruction after pc; wraps modulo 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] cause_code(input logic ext_wins);
      return ext_wins ? CAUSE_MEI : CAUSE_MTI;
   endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop level synchronizer for an asynchronous interrupt line.
module irq_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Metastability filter: two back-to-back flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/irq_trap_sequencer.sv
// Machine-mode trap sequencer: arbitrates external/timer interrupts, drains
// memory stalls, issues trap entry, and sequences WFI sleep and MRET return.
module irq_trap_sequencer
   import irq_pkg::*;
#(
   parameter logic [31:0] ISR_PC   = ISR_PC_DEFAULT,
   parameter int unsigned IRQ_SYNC = 1,
   parameter int unsigned LAT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ext_irq,
   input  logic             timer_irq,
   input  logic             csr_mstatus_mie,
   input  logic             csr_mie_meie,
   input  logic             csr_mie_mtie,
   input  logic             im_stall,
   input  logic             dm_stall,
   input  logic             exe_wfi,
   input  logic             exe_mret,
   input  logic [31:0]      exe_pc,
   output logic             trap_take,
   output logic [31:0]      trap_cause,
   output logic [31:0]      trap_epc,
   output logic [31:0]      trap_pc,
   output logic             mret_take,
   output logic             pipe_flush,
   output logic             pipe_hold,
   output logic             in_isr,
   output logic [LAT_W-1:0] last_latency
);

   localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};
   localparam logic [LAT_W-1:0] LAT_MAX  = {LAT_W{1'b1}};
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1'b1);

   logic             w_ext_s;
   logic             w_tmr_s;
   logic             w_stall;
   logic             w_pend_e;
   logic             w_pend_t;
   logic             w_pending;
   logic [31:0]      w_sel_cause;
   logic [31:0]      w_wfi_epc;
   logic [31:0]      w_run_epc;
   logic [LAT_W-1:0] w_lat_inc;

   irq_state_e       r_state;
   logic [31:0]      r_epc;
   logic [LAT_W-1:0] r_lat_cnt;
   logic [LAT_W-1:0] r_last_lat;
   logic             r_trap_take;
   logic [31:0]      r_trap_cause;
   logic [31:0]      r_trap_epc;
   logic             r_mret_take;
   logic             r_pipe_flush;
   logic             r_pipe_hold;
   logic             r_in_isr;

   generate
      if (IRQ_SYNC != 32'd0) begin : g_sync
         irq_sync u_sync_ext (.clk(clk), .rst(rst), .i_d(ext_irq),   .o_q(w_ext_s));
         irq_sync u_sync_tmr (.clk(clk), .rst(rst), .i_d(timer_irq), .o_q(w_tmr_s));
      end else begin : g_direct
         assign w_ext_s = ext_irq;
         assign w_tmr_s = timer_irq;
      end
   endgenerate

   assign w_stall     = im_stall | dm_stall;
   assign w_pend_e    = w_ext_s & csr_mie_meie;
   assign w_pend_t    = w_tmr_s & csr_mie_mtie;
   assign w_pending   = w_pend_e | w_pend_t;
   assign w_sel_cause = cause_code(w_pend_e);
   assign w_wfi_epc   = next_pc(exe_pc);
   assign w_run_epc   = exe_wfi ? w_wfi_epc : exe_pc;
   assign w_lat_inc   = (r_lat_cnt == LAT_MAX) ? LAT_MAX : r_lat_cnt + LAT_ONE;

   // Pending-to-trap latency counter; frozen while entering or in the handler.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lat_cnt <= LAT_ZERO;
      end else begin
         case (r_state)
            RUN:          r_lat_cnt <= w_pending ? w_lat_inc : LAT_ZERO;
            DRAIN, SLEEP: r_lat_cnt <= w_pending ? w_lat_inc : r_lat_cnt;
            default:      r_lat_cnt <= r_lat_cnt;
         endcase
      end
   end

   // Trap FSM; every output is registered on the transition into its state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= RUN;
         r_epc        <= 32'h0000_0000;
         r_last_lat   <= LAT_ZERO;
         r_trap_take  <= 1'b0;
         r_trap_cause <= 32'h0000_0000;
         r_trap_epc   <= 32'h0000_0000;
         r_mret_take  <= 1'b0;
         r_pipe_flush <= 1'b0;
         r_pipe_hold  <= 1'b0;
         r_in_isr     <= 1'b0;
      end else begin
         r_trap_take  <= 1'b0;
         r_trap_cause <= 32'h0000_0000;
         r_trap_epc   <= 32'h0000_0000;
         r_mret_take  <= 1'b0;
         r_pipe_flush <= 1'b0;
         r_pipe_hold  <= 1'b0;
         r_in_isr     <= 1'b0;
         case (r_state)
            RUN: begin
               // An interrupt outranks a WFI or MRET sitting in EXE.
               if (w_pending & csr_mstatus_mie) begin
                  r_epc <= w_run_epc;
                  if (w_stall) begin
                     r_state <= DRAIN;
                  end else begin
                     r_state      <= ENTER;
                     r_trap_take  <= 1'b1;
                     r_pipe_flush <= 1'b1;
                     r_trap_cause <= w_sel_cause;
                     r_trap_epc   <= w_run_epc;
                  end
               end else if (exe_wfi & ~w_stall) begin
                  r_state     <= SLEEP;
                  r_epc       <= w_wfi_epc;
                  r_pipe_hold <= 1'b1;
               end else if (exe_mret & ~w_stall) begin
                  r_mret_take  <= 1'b1;
                  r_pipe_flush <= 1'b1;
               end else begin
                  r_state <= RUN;
               end
            end
            DRAIN: begin
               if (~w_pending | ~csr_mstatus_mie) begin
                  r_state <= RUN;
               end else if (w_stall) begin
                  r_state <= DRAIN;
               end else begin
                  r_state      <= ENTER;
                  r_trap_take  <= 1'b1;
                  r_pipe_flush <= 1'b1;
                  r_trap_cause <= w_sel_cause;
                  r_trap_epc   <= r_epc;
               end
            end
            ENTER: begin
               r_last_lat <= r_lat_cnt;
               r_state    <= ISR;
               r_in_isr   <= 1'b1;
            end
            ISR: begin
               if (exe_mret & ~w_stall) begin
                  r_state      <= RUN;
                  r_mret_take  <= 1'b1;
                  r_pipe_flush <= 1'b1;
               end else begin
                  r_in_isr <= 1'b1;
               end
            end
            SLEEP: begin
               // Wake ignores MIE; MIE only decides between trapping and resuming.
               if (w_pending & csr_mstatus_mie) begin
                  r_state      <= ENTER;
                  r_trap_take  <= 1'b1;
                  r_pipe_flush <= 1'b1;
                  r_trap_cause <= w_sel_cause;
                  r_trap_epc   <= r_epc;
               end else if (w_pending) begin
                  r_state <= RUN;
               end else begin
                  r_pipe_hold <= 1'b1;
               end
            end
            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end

   assign trap_take    = r_trap_take;
   assign trap_cause   = r_trap_cause;
   assign trap_epc     = r_trap_epc;
   assign trap_pc      = ISR_PC;
   assign mret_take    = r_mret_take;
   assign pipe_flush   = r_pipe_flush;
   assign pipe_hold    = r_pipe_hold;
   assign in_isr       = r_in_isr;
   assign last_latency = r_last_lat;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Directed bench for irq_trap_sequencer: behavioural model compared every
// cycle, plus hand-computed literal checks and a synchronized/saturating twin.
module tb_irq_trap_sequencer;

   localparam logic [31:0] MEI = 32'h8000_000B;
   localparam logic [31:0] MTI = 32'h8000_0007;
   localparam logic [31:0] VEC = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ext_irq, timer_irq, csr_mstatus_mie, csr_mie_meie, csr_mie_mtie;
   logic        im_stall, dm_stall, exe_wfi, exe_mret;
   logic [31:0] exe_pc;

   logic        trap_take, mret_take, pipe_flush, pipe_hold, in_isr;
   logic [31:0] trap_cause, trap_epc, trap_pc;
   logic [15:0] last_latency;

   logic        s_trap_take, s_mret_take, s_pipe_flush, s_pipe_hold, s_in_isr;
   logic [31:0] s_trap_cause, s_trap_epc, s_trap_pc;
   logic [2:0]  s_last_latency;

   irq_trap_sequencer #(.ISR_PC(32'h0001_0000), .IRQ_SYNC(0), .LAT_W(16)) dut (
      .clk(clk), .rst(rst), .ext_irq(ext_irq), .timer_irq(timer_irq),
      .csr_mstatus_mie(csr_mstatus_mie), .csr_mie_meie(csr_mie_meie), .csr_mie_mtie(csr_mie_mtie),
      .im_stall(im_stall), .dm_stall(dm_stall), .exe_wfi(exe_wfi), .exe_mret(exe_mret),
      .exe_pc(exe_pc), .trap_take(trap_take), .trap_cause(trap_cause), .trap_epc(trap_epc),
      .trap_pc(trap_pc), .mret_take(mret_take), .pipe_flush(pipe_flush), .pipe_hold(pipe_hold),
      .in_isr(in_isr), .last_latency(last_latency));

   irq_trap_sequencer #(.ISR_PC(32'h0001_0000), .IRQ_SYNC(1), .LAT_W(3)) dut_sync (
      .clk(clk), .rst(rst), .ext_irq(ext_irq), .timer_irq(timer_irq),
      .csr_mstatus_mie(csr_mstatus_mie), .csr_mie_meie(csr_mie_meie), .csr_mie_mtie(csr_mie_mtie),
      .im_stall(im_stall), .dm_stall(dm_stall), .exe_wfi(exe_wfi), .exe_mret(exe_mret),
      .exe_pc(exe_pc), .trap_take(s_trap_take), .trap_cause(s_trap_cause), .trap_epc(s_trap_epc),
      .trap_pc(s_trap_pc), .mret_take(s_mret_take), .pipe_flush(s_pipe_flush), .pipe_hold(s_pipe_hold),
      .in_isr(s_in_isr), .last_latency(s_last_latency));

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   bit          m_sleep, m_wait, m_handler, m_enter;
   logic [31:0] m_epc = 32'h0, m_cause = 32'h0;
   int          m_lat = 0, m_lastlat = 0;
   logic        e_take = 1'b0, e_mret = 1'b0, e_flush = 1'b0, e_hold = 1'b0, e_isr = 1'b0;
   logic [31:0] e_cause = 32'h0, e_epc = 32'h0;
   logic [15:0] e_lat = 16'h0;

   task automatic bump();
      if (m_lat < 65535) m_lat++;
   endtask

   task automatic model_reset();
      m_sleep = 0; m_wait = 0; m_handler = 0; m_enter = 0;
      m_epc = 32'h0; m_cause = 32'h0; m_lat = 0; m_lastlat = 0;
      e_take = 1'b0; e_mret = 1'b0; e_flush = 1'b0; e_hold = 1'b0; e_isr = 1'b0;
      e_cause = 32'h0; e_epc = 32'h0; e_lat = 16'h0;
   endtask

   task automatic model_step();
      logic pe, pt, pend, stl;
      logic [31:0] now_cause;
      pe = ext_irq & csr_mie_meie;
      pt = timer_irq & csr_mie_mtie;
      pend = pe | pt;
      stl = im_stall | dm_stall;
      now_cause = pe ? MEI : MTI;
      e_mret = 1'b0;
      if (m_enter) begin
         m_lastlat = m_lat; m_enter = 0; m_handler = 1;
      end else if (m_handler) begin
         if (exe_mret && !stl) begin m_handler = 0; e_mret = 1'b1; end
      end else if (m_sleep) begin
         if (pend) begin
            bump(); m_sleep = 0;
            if (csr_mstatus_mie) begin m_cause = now_cause; m_enter = 1; end
         end
      end else if (m_wait) begin
         if (pend) bump();
         if (!pend || !csr_mstatus_mie) m_wait = 0;
         else begin
            m_cause = now_cause;
            if (!stl) begin m_wait = 0; m_enter = 1; end
         end
      end else begin
         if (pend) bump(); else m_lat = 0;
         if (pend && csr_mstatus_mie) begin
            m_cause = now_cause;
            m_epc = exe_wfi ? exe_pc + 32'd4 : exe_pc;
            if (stl) m_wait = 1; else m_enter = 1;
         end else if (exe_wfi && !stl) begin
            m_sleep = 1; m_epc = exe_pc + 32'd4;
         end else if (exe_mret && !stl) begin
            e_mret = 1'b1;
         end
      end
      e_take  = m_enter;
      e_cause = m_enter ? m_cause : 32'h0;
      e_epc   = m_enter ? m_epc : 32'h0;
      e_hold  = m_sleep;
      e_isr   = m_handler;
      e_flush = m_enter | e_mret;
      e_lat   = 16'(m_lastlat);
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("cyc.trap_take",    trap_take,    e_take);
         chk("cyc.trap_cause",   trap_cause,   e_cause);
         chk("cyc.trap_epc",     trap_epc,     e_epc);
         chk("cyc.trap_pc",      trap_pc,      VEC);
         chk("cyc.mret_take",    mret_take,    e_mret);
         chk("cyc.pipe_flush",   pipe_flush,   e_flush);
         chk("cyc.pipe_hold",    pipe_hold,    e_hold);
         chk("cyc.in_isr",       in_isr,       e_isr);
         chk("cyc.last_latency", last_latency, e_lat);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_inputs();
      ext_irq = 1'b0; timer_irq = 1'b0; csr_mstatus_mie = 1'b0; csr_mie_meie = 1'b0;
      csr_mie_mtie = 1'b0; im_stall = 1'b0; dm_stall = 1'b0; exe_wfi = 1'b0;
      exe_mret = 1'b0; exe_pc = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      ticks(2);
      rst = 1'b0;
   endtask

   task automatic reset_now_check(input string tag);
      rst = 1'b1;
      clear_inputs();
      #1;
      chk({tag, ".take"},  trap_take,  1'b0);
      chk({tag, ".flush"}, pipe_flush, 1'b0);
      chk({tag, ".hold"},  pipe_hold,  1'b0);
      chk({tag, ".isr"},   in_isr,     1'b0);
      chk({tag, ".cause"}, trap_cause, 32'h0);
      chk({tag, ".epc"},   trap_epc,   32'h0);
      chk({tag, ".vec"},   trap_pc,    VEC);
      ticks(2);
      rst = 1'b0;
   endtask

   initial begin
      clear_inputs();
      ticks(3);
      rst = 1'b0;
      chk("reset.trap_pc", trap_pc, VEC);
      chk("reset.last_latency", last_latency, 16'h0);

      // Basic external trap, then MRET with an instruction stall.
      csr_mstatus_mie = 1'b1; csr_mie_meie = 1'b1; exe_pc = 32'h0000_0100; ext_irq = 1'b1;
      tick();
      chk("basic.take", trap_take, 1'b1);
      chk("basic.cause", trap_cause, MEI);
      chk("basic.epc", trap_epc, 32'h0000_0100);
      chk("basic.vec", trap_pc, VEC);
      chk("basic.flush", pipe_flush, 1'b1);
      chk("sync.take_e1", s_trap_take, 1'b0);
      tick();
      chk("basic.latency", last_latency, 16'd1);
      chk("basic.in_isr", in_isr, 1'b1);
      chk("basic.take_once", trap_take, 1'b0);
      chk("sync.take_e2", s_trap_take, 1'b0);
      tick();
      chk("sync.take_e3", s_trap_take, 1'b1);
      chk("sync.cause", s_trap_cause, MEI);
      ext_irq = 1'b0;
      tick();
      chk("sync.latency", s_last_latency, 3'd1);
      exe_mret = 1'b1; im_stall = 1'b1;
      ticks(2);
      chk("mret.stalled", mret_take, 1'b0);
      chk("mret.still_isr", in_isr, 1'b1);
      im_stall = 1'b0;
      tick();
      chk("mret.take", mret_take, 1'b1);
      chk("mret.flush", pipe_flush, 1'b1);
      chk("mret.in_isr", in_isr, 1'b0);
      exe_mret = 1'b0;
      tick();
      chk("mret.once", mret_take, 1'b0);

      // Simultaneous sources with a 3-cycle data stall.
      do_reset();
      csr_mstatus_mie = 1'b1; csr_mie_meie = 1'b1; csr_mie_mtie = 1'b1;
      exe_pc = 32'h0000_0300; ext_irq = 1'b1; timer_irq = 1'b1; dm_stall = 1'b1;
      ticks(3);
      chk("drain.no_take", trap_take, 1'b0);
      dm_stall = 1'b0;
      tick();
      chk("drain.take", trap_take, 1'b1);
      chk("drain.cause", trap_cause, MEI);
      chk("drain.epc", trap_epc, 32'h0000_0300);
      tick();
      chk("drain.latency", last_latency, 16'd4);
      ext_irq = 1'b0;
      ticks(3);
      chk("nest.no_take", trap_take, 1'b0);
      chk("nest.in_isr", in_isr, 1'b1);
      exe_mret = 1'b1;
      tick();
      exe_mret = 1'b0;
      tick();
      chk("retrap.take", trap_take, 1'b1);
      chk("retrap.cause", trap_cause, MTI);
      timer_irq = 1'b0;
      ticks(2);

      // WFI sleep, wake into a trap.
      do_reset();
      csr_mstatus_mie = 1'b1; csr_mie_meie = 1'b1; exe_pc = 32'h0000_0200; exe_wfi = 1'b1;
      tick();
      chk("wfi1.hold", pipe_hold, 1'b1);
      exe_wfi = 1'b0; exe_pc = 32'h0000_0500;
      ticks(10);
      chk("wfi1.hold10", pipe_hold, 1'b1);
      ext_irq = 1'b1;
      tick();
      chk("wfi1.take", trap_take, 1'b1);
      chk("wfi1.epc", trap_epc, 32'h0000_0204);
      chk("wfi1.hold_off", pipe_hold, 1'b0);
      ext_irq = 1'b0;
      ticks(2);

      // WFI sleep with MIE clear: wake and resume.
      do_reset();
      csr_mie_meie = 1'b1; exe_pc = 32'h0000_0200; exe_wfi = 1'b1;
      tick();
      exe_wfi = 1'b0;
      ticks(10);
      ext_irq = 1'b1;
      tick();
      chk("wfi0.hold_off", pipe_hold, 1'b0);
      chk("wfi0.no_take", trap_take, 1'b0);
      ticks(3);
      chk("wfi0.still_run", in_isr, 1'b0);
      ext_irq = 1'b0;

      // DRAIN aborts: source drops, then MIE drops; then a cause upgrade.
      do_reset();
      csr_mstatus_mie = 1'b1; csr_mie_meie = 1'b1; csr_mie_mtie = 1'b1;
      ext_irq = 1'b1; im_stall = 1'b1;
      ticks(2);
      ext_irq = 1'b0;
      tick();
      im_stall = 1'b0;
      ticks(3);
      chk("abort.no_take", trap_take, 1'b0);
      ext_irq = 1'b1; dm_stall = 1'b1;
      tick();
      csr_mstatus_mie = 1'b0;
      tick();
      ext_irq = 1'b0; dm_stall = 1'b0; csr_mstatus_mie = 1'b1;
      tick();
      chk("abort_mie.no_take", trap_take, 1'b0);
      timer_irq = 1'b1; dm_stall = 1'b1;
      tick();
      ext_irq = 1'b1;
      tick();
      dm_stall = 1'b0;
      tick();
      chk("upgrade.take", trap_take, 1'b1);
      chk("upgrade.cause", trap_cause, MEI);
      ext_irq = 1'b0; timer_irq = 1'b0;
      ticks(2);

      // MRET in RUN, and interrupt beating WFI with EPC wrap.
      do_reset();
      exe_mret = 1'b1;
      tick();
      chk("run_mret.take", mret_take, 1'b1);
      chk("run_mret.flush", pipe_flush, 1'b1);
      exe_mret = 1'b0;
      tick();
      csr_mstatus_mie = 1'b1; csr_mie_meie = 1'b1; ext_irq = 1'b1;
      exe_wfi = 1'b1; exe_pc = 32'hFFFF_FFFC;
      tick();
      chk("wrap.take", trap_take, 1'b1);
      chk("wrap.epc", trap_epc, 32'h0000_0000);
      chk("wrap.no_hold", pipe_hold, 1'b0);
      exe_wfi = 1'b0; ext_irq = 1'b0;
      ticks(2);

      // Reset while sleeping and while entering a trap.
      do_reset();
      exe_pc = 32'h0000_0200; exe_wfi = 1'b1;
      tick();
      exe_wfi = 1'b0;
      tick();
      chk("rst_sleep.pre_hold", pipe_hold, 1'b1);
      reset_now_check("rst_sleep");
      ticks(5);
      chk("rst_sleep.quiet", trap_take | mret_take, 1'b0);
      csr_mstatus_mie = 1'b1; csr_mie_meie = 1'b1; exe_pc = 32'h0000_0040; ext_irq = 1'b1;
      tick();
      chk("rst_enter.pre_take", trap_take, 1'b1);
      reset_now_check("rst_enter");
      ticks(4);
      chk("rst_enter.latency", last_latency, 16'h0);
      chk("rst_enter.quiet", trap_take | mret_take | in_isr, 1'b0);

      // Long drain: latency on the 16-bit and saturating 3-bit counters.
      do_reset();
      csr_mstatus_mie = 1'b1; csr_mie_meie = 1'b1; ext_irq = 1'b1; dm_stall = 1'b1;
      ticks(12);
      dm_stall = 1'b0;
      ticks(4);
      chk("long.latency", last_latency, 16'd13);
      chk("sat.latency", s_last_latency, 3'd7);
      ext_irq = 1'b0;
      ticks(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/irq_trap_sequencer.md
Name: irq_trap_sequencer

Overview:
Machine-mode trap sequencer between the interrupt sources and the CSR/pipeline. The sources are the DMA external interrupt and the WDT timer interrupt.
- Arbitrates pending interrupts (external over timer).
- Waits for instruction- and data-memory stalls to drain, then issues a one-cycle trap-entry command: cause, EPC, ISR target and flush.
- Sequences WFI sleep/wake and MRET return.
- Blocks nested traps while the ISR runs.

Parameters:
ISR_PC, 32'h0001_0000, trap target address driven on trap_pc.
IRQ_SYNC, 1, 1 = 2-flop synchronizer on ext_irq/timer_irq (adds 2 cycles); 0 = direct.
LAT_W, 16, width of the saturating interrupt-latency counter.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ext_irq  in  1  DMA interrupt, level
timer_irq  in  1  WDT timeout interrupt, level
csr_mstatus_mie  in  1  mstatus.MIE
csr_mie_meie  in  1  mie.MEIE
csr_mie_mtie  in  1  mie.MTIE
im_stall  in  1  instruction-memory stall
dm_stall  in  1  data-memory stall
exe_wfi  in  1  valid WFI in EXE
exe_mret  in  1  valid MRET in EXE
exe_pc  in  32  PC of EXE instruction
trap_take  out  1  one-cycle trap-entry pulse to CSR (save MIE->MPIE, clear MIE, MPP=11)
trap_cause  out  32  mcause: 32'h8000_000B external, 32'h8000_0007 timer
trap_epc  out  32  return PC for mepc
trap_pc  out  32  constant ISR_PC
mret_take  out  1  one-cycle MRET commit pulse to CSR
pipe_flush  out  1  flush IF/ID/EXE, redirect PC
pipe_hold  out  1  freeze fetch (SLEEP)
in_isr  out  1  handler active
last_latency  out  LAT_W  cycles from pending to trap_take of the most recent trap

Behaviour:
- Signal definitions:
  - stall = im_stall | dm_stall.
  - pend_e = ext_s & csr_mie_meie; pend_t = timer_s & csr_mie_mtie, where *_s is the synchronized or direct input.
  - pending = pend_e | pend_t; sel = pend_e ? EXT : TMR.
- Reset: state RUN. All outputs 0 except trap_pc = ISR_PC. Latched cause/EPC and last_latency are 0.
- Reset asserted mid-operation aborts any state to RUN with no pulse emitted.
- RUN:
  - If pending & csr_mstatus_mie: latch cause = sel and EPC.
    - EPC = exe_pc+4 if exe_wfi, else exe_pc.
    - Go to ENTER if ~stall, else DRAIN.
    - An interrupt beats an exe_mret or exe_wfi in the same cycle.
  - Else if exe_wfi & ~stall: go to SLEEP and latch EPC = exe_pc+4.
  - Else if exe_mret & ~stall: pulse mret_take and pipe_flush for 1 cycle; stay in RUN.
- DRAIN:
  - Wait while stall.
  - Cause is re-evaluated every cycle; an external interrupt upgrades a latched timer cause.
  - If pending drops or csr_mstatus_mie drops: return to RUN, no trap.
  - When stall clears: go to ENTER.
- ENTER (exactly 1 cycle):
  - trap_take = pipe_flush = 1; trap_cause and trap_epc are valid this cycle only, 0 otherwise.
  - last_latency <= lat_cnt.
  - Go to ISR.
- ISR:
  - in_isr = 1; new pending interrupts are ignored (no nesting).
  - exe_mret & ~stall: mret_take = pipe_flush = 1 for 1 cycle, then RUN.
  - exe_wfi inside ISR is a NOP.
- SLEEP:
  - pipe_hold = 1.
  - Wakes on pending regardless of csr_mstatus_mie.
  - If csr_mstatus_mie: go to ENTER, cause = sel, EPC = latched exe_pc+4; pipe_hold drops in ENTER.
  - Else: go to RUN, pipe_hold drops, execution resumes at the next instruction.
- Latency counter:
  - lat_cnt clears in RUN when ~pending.
  - It increments each cycle pending is high in RUN/DRAIN/SLEEP and saturates at all-ones.
- Timing and arithmetic:
  - Minimum latency is 1 cycle: pending registered in RUN, trap_take in the next cycle.
  - IRQ_SYNC=1 adds 2 cycles.
  - EPC addition is 32-bit modulo: exe_pc = 32'hFFFF_FFFC gives EPC 32'h0.
- Outputs are registered from state; there is no combinational path from inputs to trap_take or mret_take.

Decomposition:
- Shared package irq_pkg holds:
  - the state enum {RUN, DRAIN, ENTER, ISR, SLEEP};
  - cause constants CAUSE_MEI = 32'h8000_000B and CAUSE_MTI = 32'h8000_0007;
  - the default ISR_PC.
- One sub-module, irq_sync: a 2-flop level synchronizer with async active-high reset, instantiated per source under IRQ_SYNC.

Test Plan:
- Basic external trap (IRQ_SYNC=0, MIE=1, MEIE=1, no stall): ext_irq rises with exe_pc = 32'h0000_0100 -> next cycle trap_take = 1, cause 32'h8000_000B, epc 32'h0000_0100, trap_pc 32'h0001_0000, last_latency = 1.
- Simultaneous sources with stall: ext_irq and timer_irq together (MEIE = MTIE = 1) and dm_stall held 3 cycles -> DRAIN 3 cycles, then trap_take with cause 32'h8000_000B, last_latency = 4; timer_irq is not taken while in_isr.
- WFI sleep and wake: exe_wfi at exe_pc = 32'h200 -> pipe_hold = 1. Case MIE=1: ext_irq after 10 cycles -> ENTER, epc = 32'h204. Case MIE=0: same stimulus -> RUN, pipe_hold = 0, no trap_take.
- MRET return: in ISR, exe_mret with im_stall = 1 for 2 cycles -> no pulse during stall, then mret_take = pipe_flush = 1 for 1 cycle, then RUN, in_isr = 0.
- DRAIN abort: pending then ext_irq deasserts during DRAIN -> RUN, trap_take never asserts.
- Reset in SLEEP and in ENTER: rst = 1 -> all outputs 0 immediately, state RUN; after release with no irq, no pulses.
